// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   state_t      : sweep FSM states (CLEAR while zeroing the array, RUN afterwards)
//   DEF_*        : default parameter values used by regfile_mp
`timescale 1ns/1ps
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_XLEN     = 32;
    localparam int DEF_NREG     = 32;
    localparam int DEF_NRP      = 2;
    localparam int DEF_ZERO_REG = 1;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of the register file.
// The port's output is chosen in priority order: forced zero, hard-wired
// register 0, write-through bypass, stored value.
//   raddr   : register index read by this port
//   waddr   : index being written this cycle
//   wdata   : data being written this cycle
//   byp_en  : a write is committing this cycle (RUN, we=1, no reset)
//   blank   : array not yet valid (CLEAR or reset), return zero
//   mem_val : stored contents at raddr
//   rdata   : read result
`timescale 1ns/1ps
module regfile_rdport #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0]   raddr,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            byp_en,
    input  logic            blank,
    input  logic [XLEN-1:0] mem_val,
    output logic [XLEN-1:0] rdata
);

    logic zero_hit;
    logic byp_hit;

    // Register 0 wins over the bypass so a write to x0 is never visible.
    assign zero_hit = (ZERO_REG != 0) && (raddr == '0);
    assign byp_hit  = byp_en && (raddr == waddr);

    always_comb begin
        rdata = mem_val;
        if (blank || zero_hit) begin
            rdata = '0;
        end else if (byp_hit) begin
            rdata = wdata;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with one write port, NRP asynchronous read ports,
// write-through bypass, optional hard-wired zero register, and a
// one-register-per-cycle clearing sweep after reset.
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous active-high reset, restarts the clearing sweep
//   we    : write enable (ignored until ready)
//   waddr : write index
//   wdata : write data
//   raddr : read indices, one per port
//   rdata : read data, one per port, combinational
//   ready : registered flag, high once the sweep has finished
`timescale 1ns/1ps
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int   XLEN     = DEF_XLEN,
    parameter int   NREG     = DEF_NREG,
    parameter int   NRP      = DEF_NRP,
    parameter int   ZERO_REG = DEF_ZERO_REG,
    localparam int  AW       = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [AW-1:0]             waddr,
    input  logic [XLEN-1:0]           wdata,
    input  logic [NRP-1:0][AW-1:0]    raddr,
    output logic [NRP-1:0][XLEN-1:0]  rdata,
    output logic                      ready
);

    state_t          state;
    logic [AW-1:0]   clr_idx;
    logic [XLEN-1:0] mem [NREG];

    logic run;
    logic wr_en;
    logic byp_en;
    logic blank;

    assign run    = (state == RUN);
    assign byp_en = run && we && !rst;
    assign blank  = !run || rst;
    assign wr_en  = byp_en && !((ZERO_REG != 0) && (waddr == '0));

    // Sweep FSM: clears index clr_idx each CLEAR cycle, enters RUN after
    // the last index. ready is registered alongside the state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + AW'(1);
            if (clr_idx == AW'(NREG - 1)) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end
    end

    // Storage has no reset of its own; the sweep provides the zeroing.
    // A reset cycle blocks both sweep and user writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (wr_en) begin
                mem[waddr] <= wdata;
            end
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        regfile_rdport #(
            .XLEN     (XLEN),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .raddr   (raddr[p]),
            .waddr   (waddr),
            .wdata   (wdata),
            .byp_en  (byp_en),
            .blank   (blank),
            .mem_val (mem[raddr[p]]),
            .rdata   (rdata[p])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three instances cover the default
// configuration, ZERO_REG=0, and XLEN=64/NREG=16/NRP=3.
`timescale 1ns/1ps
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // u_a (ZERO_REG=1) and u_b (ZERO_REG=0) share every input.
    logic             rst, we;
    logic [4:0]       waddr;
    logic [31:0]      wdata;
    logic [1:0][4:0]  raddr;
    logic [1:0][31:0] rdata_a, rdata_b;
    logic             ready_a, ready_b;

    logic             rst2, we2;
    logic [3:0]       waddr2;
    logic [63:0]      wdata2;
    logic [2:0][3:0]  raddr2;
    logic [2:0][63:0] rdata2;
    logic             ready2;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mp #(.XLEN(32), .NREG(32), .NRP(2), .ZERO_REG(1)) u_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_a), .ready(ready_a));

    regfile_mp #(.XLEN(32), .NREG(32), .NRP(2), .ZERO_REG(0)) u_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .ready(ready_b));

    regfile_mp #(.XLEN(64), .NREG(16), .NRP(3), .ZERO_REG(1)) u_c (
        .clk(clk), .rst(rst2), .we(we2), .waddr(waddr2), .wdata(wdata2),
        .raddr(raddr2), .rdata(rdata2), .ready(ready2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with ready low, starting just after the reset edge.
    task automatic count_clear_a(output int cnt);
        cnt = 0;
        while (!ready_a && cnt < 200) begin
            cnt++;
            step();
        end
    endtask

    task automatic count_clear_c(output int cnt);
        cnt = 0;
        while (!ready2 && cnt < 200) begin
            cnt++;
            step();
        end
    endtask

    int cnt;
    int bad;

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        rst2 = 1'b1; we2 = 1'b0; waddr2 = '0; wdata2 = '0; raddr2 = '0;

        // ---------------- default config: reset sweep ----------------
        raddr[0] = 5'd3; raddr[1] = 5'd9;
        #1;
        check("rst_rd_a0", 64'(rdata_a[0]), 64'h0);
        check("rst_rd_b1", 64'(rdata_b[1]), 64'h0);
        step();
        rst = 1'b0;
        check("ready_after_rst", 64'(ready_a), 64'h0);
        check("clear_rd", 64'(rdata_a[0]), 64'h0);
        count_clear_a(cnt);
        check("clear_len_a", 64'(cnt), 64'd32);
        check("ready_b", 64'(ready_b), 64'h1);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            raddr[0] = 5'(i); raddr[1] = 5'(31 - i);
            #1;
            if (rdata_a[0] !== 32'h0 || rdata_a[1] !== 32'h0 || rdata_b[0] !== 32'h0) bad++;
        end
        check("all_zero_after_clear", 64'(bad), 64'd0);

        // ---------------- write / read ----------------
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr[0] = 5'd5; raddr[1] = 5'd6;
        #1;
        check("wr_bypass_x5", 64'(rdata_a[0]), 64'hDEADBEEF);
        check("wr_other_x6", 64'(rdata_a[1]), 64'h0);
        step();
        we = 1'b0; wdata = 32'h0;
        #1;
        check("rd_x5_next", 64'(rdata_a[0]), 64'hDEADBEEF);
        step();
        check("rd_x5_later", 64'(rdata_a[0]), 64'hDEADBEEF);

        // ---------------- bypass on both ports ----------------
        raddr[0] = 5'd7; raddr[1] = 5'd7;
        #1;
        check("x7_before", 64'(rdata_a[0]), 64'h0);
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
        #1;
        check("byp_p0", 64'(rdata_a[0]), 64'h12345678);
        check("byp_p1", 64'(rdata_a[1]), 64'h12345678);
        step();
        we = 1'b0; wdata = 32'h0;
        #1;
        check("x7_stored", 64'(rdata_a[1]), 64'h12345678);

        // ---------------- zero register ----------------
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr[0] = 5'd0; raddr[1] = 5'd0;
        #1;
        check("x0_wcyc_z1", 64'(rdata_a[0]), 64'h0);
        check("x0_wcyc_z0", 64'(rdata_b[1]), 64'hFFFFFFFF);
        step();
        we = 1'b0; wdata = 32'h0;
        #1;
        check("x0_after_z1", 64'(rdata_a[1]), 64'h0);
        check("x0_after_z0", 64'(rdata_b[0]), 64'hFFFFFFFF);

        // ---------------- reset in RUN hides bypass ----------------
        rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'h55555555; raddr[0] = 5'd5;
        #1;
        check("rst_blocks_byp", 64'(rdata_a[0]), 64'h0);
        step();
        rst = 1'b0; we = 1'b0;
        // ---------------- reset mid-sweep ----------------
        for (int i = 0; i < 10; i++) begin
            we = 1'b1; waddr = 5'(i + 1); wdata = 32'hA5A50000 | 32'(i);
            step();
        end
        check("mid_sweep_ready", 64'(ready_a), 64'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cnt = 0; bad = 0;
        while (!ready_a && cnt < 200) begin
            we = 1'b1; waddr = 5'(cnt); wdata = 32'hC0DE0000 | 32'(cnt); raddr[0] = 5'(cnt);
            #1;
            if (rdata_a[0] !== 32'h0 || rdata_b[0] !== 32'h0) bad++;
            cnt++;
            step();
        end
        we = 1'b0; wdata = 32'h0;
        check("resweep_len", 64'(cnt), 64'd32);
        check("clear_rd_during_we", 64'(bad), 64'd0);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            raddr[0] = 5'(i); raddr[1] = 5'(i);
            #1;
            if (rdata_a[0] !== 32'h0 || rdata_b[1] !== 32'h0) bad++;
        end
        check("all_zero_after_resweep", 64'(bad), 64'd0);

        // ---------------- XLEN=64, NREG=16, NRP=3 ----------------
        #1;
        check("c_rst_rd", rdata2[2], 64'h0);
        step();
        rst2 = 1'b0;
        count_clear_c(cnt);
        check("c_clear_len", 64'(cnt), 64'd16);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            raddr2[0] = 4'(i); raddr2[1] = 4'(i); raddr2[2] = 4'(15 - i);
            #1;
            if (rdata2[0] !== 64'h0 || rdata2[1] !== 64'h0 || rdata2[2] !== 64'h0) bad++;
        end
        check("c_all_zero", 64'(bad), 64'd0);

        we2 = 1'b1; waddr2 = 4'd5; wdata2 = 64'h0123456789ABCDEF; raddr2[0] = 4'd5;
        step();
        we2 = 1'b0; wdata2 = '0;
        #1;
        check("c_rd_x5", rdata2[0], 64'h0123456789ABCDEF);

        raddr2[0] = 4'd7; raddr2[1] = 4'd7; raddr2[2] = 4'd7;
        we2 = 1'b1; waddr2 = 4'd7; wdata2 = 64'hFEDCBA9812345678;
        #1;
        check("c_byp_p0", rdata2[0], 64'hFEDCBA9812345678);
        check("c_byp_p2", rdata2[2], 64'hFEDCBA9812345678);
        step();
        we2 = 1'b0; wdata2 = '0;
        #1;
        check("c_x7_stored", rdata2[1], 64'hFEDCBA9812345678);

        raddr2[0] = 4'd0; raddr2[1] = 4'd0; raddr2[2] = 4'd5;
        we2 = 1'b1; waddr2 = 4'd0; wdata2 = 64'hFFFFFFFFFFFFFFFF;
        #1;
        check("c_x0_wcyc", rdata2[1], 64'h0);
        step();
        we2 = 1'b0; wdata2 = '0;
        #1;
        check("c_x0_after", rdata2[0], 64'h0);
        check("c_x5_kept", rdata2[2], 64'h0123456789ABCDEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits.
REQ-002 Parameter NREG, default 32: register count, a power of two >= 2; AW = log2(NREG).
REQ-003 Parameter NRP, default 2: number of independent read ports, >= 1.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 SHALL read as zero and ignore writes.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 we  input  1  write enable.
REQ-008 waddr  input  AW  write register index.
REQ-009 wdata  input  XLEN  write data.
REQ-010 raddr  input  NRP x AW  read indices, one per port.
REQ-011 rdata  output  NRP x XLEN  read data, one per port, combinational.
REQ-012 ready  output  1  high when the array is initialised and accepts writes.

Function
REQ-013 The block SHALL have two states: CLEAR and RUN.
REQ-014 In CLEAR, a counter clr_idx SHALL zero one register per cycle, from index 0 to NREG-1.
REQ-015 CLEAR SHALL last exactly NREG cycles; after the cycle that clears index NREG-1, the state SHALL move to RUN.
REQ-016 ready SHALL be 0 in CLEAR and 1 in RUN; it is driven from a register with no combinational path from inputs.
REQ-017 In CLEAR, we SHALL be ignored, with no write and no queuing, and every rdata port SHALL return 0.
REQ-018 In RUN with we=1, wdata SHALL be stored at waddr on the clock edge, unless ZERO_REG=1 and waddr=0.
REQ-019 Reads SHALL be asynchronous; rdata[p] reflects array[raddr[p]] in the same cycle.
REQ-020 Write-through bypass: in RUN, if we=1 and raddr[p]=waddr, rdata[p] SHALL equal wdata in the same cycle.
REQ-021 Bypass SHALL NOT apply to index 0 when ZERO_REG=1; that read SHALL return 0.
REQ-022 When ZERO_REG=1, raddr[p]=0 SHALL return 0 on every port regardless of stored contents.
REQ-023 Ports SHALL be independent; any number of ports may address the same register, including the one being written, and each gets the same correct value.
REQ-024 Out-of-range indices cannot occur because NREG is a power of two; no range check is needed.

Reset
REQ-025 rst=1 at a clock edge SHALL force the state to CLEAR, set clr_idx=0, and drive ready=0 on the next cycle.
REQ-026 rst asserted mid-sweep SHALL restart the sweep at index 0; the total clear time counts from the last rst cycle.
REQ-027 rst asserted in RUN SHALL discard any same-cycle write.
REQ-028 While rst=1, rdata SHALL read 0 on every port.
REQ-029 Array contents are don't-care until CLEAR completes; there is no reliance on initial values or a reset fan-out to every bit.

Structure
REQ-030 A shared package regfile_pkg SHALL hold the state enum (CLEAR, RUN) and the default parameter constants.
REQ-031 The block SHALL contain one sub-module, regfile_rdport (a single read port with bypass and zero logic), instantiated NRP times in a generate loop.
REQ-032 The storage array and the sweep FSM SHALL live in regfile_mp.

Verification
REQ-033 Reset sweep: hold rst 1 cycle, NREG=32 -> ready=0 for exactly 32 cycles, then 1; all 32 registers read 0.
REQ-034 Write/read: in RUN, write 0xDEADBEEF to x5 -> rdata[0] with raddr=5 returns 0xDEADBEEF on the next cycle and afterwards.
REQ-035 Bypass: we=1, waddr=7, wdata=0x12345678, raddr[0]=raddr[1]=7 in the same cycle -> both ports return 0x12345678 combinationally.
REQ-036 Zero register: write 0xFFFFFFFF to x0 with ZERO_REG=1 -> raddr=0 returns 0 in the write cycle and afterwards; with ZERO_REG=0 it returns 0xFFFFFFFF.
REQ-037 Reset mid-sweep: assert rst at sweep cycle 10 -> ready stays 0 for 32 further cycles; writes attempted meanwhile leave every register 0.
REQ-038 Parameter sweep: XLEN=64, NREG=16, NRP=3 -> REQ-033 to REQ-036 pass with 16-cycle CLEAR.
